// File: rtl/tof_pkg.sv
// Shared constants, types and write-FSM states for the ToF ping-pong frame buffer.
package tof_pkg;

  localparam int unsigned N_SENS  = 8;
  localparam int unsigned N_ZONES = 64;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SW      = $clog2(N_SENS);
  localparam int unsigned ZW      = $clog2(N_ZONES);
  localparam int unsigned AW      = SW + ZW;

  typedef logic [AW-1:0]     tof_addr_t;
  typedef logic [DATA_W-1:0] tof_dist_t;

  typedef enum logic [0:0] {
    Fill,
    WaitFree
  } wr_state_e;

endpackage

// File: rtl/tof_frame_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with reset on the output.
module tof_frame_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tof_frame_buffer.sv
// Ping-pong capture of per-sensor ToF frames; swaps banks once every sensor has sent s_last.
module tof_frame_buffer
  import tof_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SW-1:0]     s_sens,
  input  logic [ZW-1:0]     s_zone,
  input  logic [DATA_W-1:0] s_dist,
  input  logic              s_last,
  output logic              drdy,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic [7:0]        drop_cnt
);

  wr_state_e         state_q, state_d;
  logic [N_SENS-1:0] done_mask_q, done_mask_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_bank_valid_q, rd_bank_valid_d;
  logic              drdy_q, drdy_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic mask_full, accept, dup, ram_we, do_swap;

  always_comb begin
    mask_full       = &done_mask_q;
    // Swap cycle and WAIT_FREE both stall so no beat straddles a bank change.
    s_ready         = !rst && (state_q == Fill) && !mask_full;
    accept          = s_valid && s_ready;
    dup             = done_mask_q[s_sens];
    ram_we          = accept && !dup;

    state_d         = state_q;
    done_mask_d     = done_mask_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    rd_bank_valid_d = rd_bank_valid_q;
    drop_cnt_d      = drop_cnt_q;
    drdy_d          = 1'b0;
    do_swap         = 1'b0;

    if (accept) begin
      if (dup) begin
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else if (s_last) begin
        done_mask_d[s_sens] = 1'b1;
      end
    end

    case (state_q)
      Fill: begin
        if (mask_full) begin
          if (!rd_bank_valid_q || rd_done) begin
            do_swap = 1'b1;
          end else begin
            state_d = WaitFree;
          end
        end else if (rd_done) begin
          rd_bank_valid_d = 1'b0;
        end
      end
      WaitFree: begin
        if (rd_done) begin
          do_swap = 1'b1;
          state_d = Fill;
        end
      end
      default: state_d = Fill;
    endcase

    // Swap wins over a coincident rd_done release: the read bank stays valid.
    if (do_swap) begin
      rd_bank_d       = wr_bank_q;
      wr_bank_d       = ~wr_bank_q;
      rd_bank_valid_d = 1'b1;
      done_mask_d     = '0;
      drdy_d          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= Fill;
      done_mask_q     <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      rd_bank_valid_q <= 1'b0;
      drdy_q          <= 1'b0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      done_mask_q     <= done_mask_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      rd_bank_valid_q <= rd_bank_valid_d;
      drdy_q          <= drdy_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign drdy     = drdy_q;
  assign drop_cnt = drop_cnt_q;

  tof_frame_ram #(
    .Depth(2 * N_SENS * N_ZONES),
    .Width(DATA_W),
    .AddrW(AW + 1)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (ram_we),
    .waddr_i({wr_bank_q, s_sens, s_zone}),
    .wdata_i(s_dist),
    .raddr_i({rd_bank_q, rd_addr}),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_tof_frame_buffer.sv
// Scoreboard bench for tof_frame_buffer: stimulus queues expected reads/drdy, monitor compares.
module tb_tof_frame_buffer;
  import tof_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [SW-1:0]     s_sens;
  logic [ZW-1:0]     s_zone;
  logic [DATA_W-1:0] s_dist;
  logic              s_last;
  logic              drdy;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  logic [7:0]        drop_cnt;

  tof_frame_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sens  (s_sens),
    .s_zone  (s_zone),
    .s_dist  (s_dist),
    .s_last  (s_last),
    .drdy    (drdy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_done (rd_done),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_acc;
  int exp_rd_q[$];
  int exp_drdy_q[$];
  int exp_mem[512];
  logic rd_chk = 1'b0;
  logic rd_pend = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_chk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares read data and drdy pulses against the scoreboard queues.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", int'(rd_data), exp_rd_q.pop_front());
    end
    if (drdy === 1'b1) begin
      if (exp_drdy_q.size() == 0) chk("drdy_unexpected_at_cycle", cyc, -1);
      else chk("drdy_cycle", cyc, exp_drdy_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic send(input int s, input int z, input int d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_sens  = SW'(s);
    s_zone  = ZW'(z);
    s_dist  = DATA_W'(d);
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 1000) begin
        chk("s_ready_stall", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    last_acc = cyc;
  endtask

  task automatic rd(input int a, input int exp);
    rd_addr = AW'(a);
    rd_chk  = 1'b1;
    exp_rd_q.push_back(exp);
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done(input bit expect_drdy);
    rd_done = 1'b1;
    if (expect_drdy) exp_drdy_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    rd_done = 1'b0;
  endtask

  task automatic full_frame(input int base);
    for (int s = 0; s < 8; s++)
      for (int z = 0; z < 64; z++) send(s, z, base + s * 100 + z, z == 63);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sens = '0; s_zone = '0; s_dist = '0; s_last = 1'b0;
    rd_addr = '0; rd_done = 1'b0;
    step(2);
    @(negedge clk);
    chk("reset_s_ready", int'(s_ready), 0);
    chk("reset_drdy", int'(drdy), 0);
    chk("reset_drop_cnt", int'(drop_cnt), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;

    // Single frame into bank 0, read bank free: immediate swap.
    full_frame(0);
    exp_drdy_q.push_back(last_acc + 1);
    step(2);
    rd(9'h1C5, 705);
    rd(9'h03F, 63);
    chk("f1_drop_cnt", int'(drop_cnt), 0);

    // Second frame with no release: stalls in WAIT_FREE, frame 1 still readable.
    full_frame(2000);
    @(negedge clk);
    @(negedge clk);
    chk("f2_wait_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    rd(9'h1C5, 705);
    rd(9'h000, 0);
    step(6);
    pulse_done(1'b1);
    @(negedge clk);
    chk("f2_after_swap_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    rd(9'h1C5, 2705);
    rd(9'h03F, 2063);

    // Release in the same cycle the mask completes: single swap, no stall.
    full_frame(4000);
    pulse_done(1'b1);
    @(negedge clk);
    chk("coincident_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    rd(9'h1C5, 4705);

    // Duplicate sensor-3 beats are dropped and counted, saturating at 255.
    for (int z = 0; z < 64; z++) send(3, z, 6300 + z, z == 63);
    for (int i = 0; i < 5; i++) send(3, i, 16'hFFFF, i == 4);
    @(negedge clk);
    chk("dup_drop_cnt_5", int'(drop_cnt), 5);
    chk("dup_s_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) send(3, i % 64, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("dup_drop_cnt_sat", int'(drop_cnt), 255);
    @(posedge clk); #1;
    for (int s = 0; s < 8; s++)
      if (s != 3) for (int z = 0; z < 64; z++) send(s, z, 6000 + s * 100 + z, z == 63);
    // Read bank still valid from the coincident swap, so this frame must wait.
    @(negedge clk);
    @(negedge clk);
    chk("f4_wait_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    pulse_done(1'b1);
    step(1);
    for (int z = 0; z < 5; z++) rd(3 * 64 + z, 6300 + z);
    rd(3 * 64 + 63, 6363);
    rd(9'h1C5, 6705);
    chk("f4_drop_cnt_held", int'(drop_cnt), 255);

    // Reset mid-frame, then a fresh frame completes after exactly 512 beats.
    for (int i = 0; i < 200; i++) send(i / 64, i % 64, 7000 + i, (i % 64) == 63);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_drdy", int'(drdy), 0);
    chk("midrst_drop_cnt", int'(drop_cnt), 0);
    chk("midrst_s_ready_after", int'(s_ready), 1);
    @(posedge clk); #1;
    full_frame(8000);
    exp_drdy_q.push_back(last_acc + 1);
    step(2);
    rd(9'h1C5, 8705);
    chk("fresh_drop_cnt", int'(drop_cnt), 0);

    // Release with no pending swap clears validity; interleaved frame then swaps at once.
    pulse_done(1'b0);
    step(1);
    for (int z = 0; z < 64; z++)
      for (int s = 0; s < 8; s++) begin
        exp_mem[s * 64 + z] = 9000 + s * 100 + z;
        send(s, z, exp_mem[s * 64 + z], z == 63);
        step($urandom_range(0, 2));
      end
    exp_drdy_q.push_back(last_acc + 1);
    step(3);
    for (int a = 0; a < 512; a++) rd(a, exp_mem[a]);
    step(3);

    chk("drdy_queue_drained", exp_drdy_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tof_frame_buffer.md
Name: tof_frame_buffer

Overview:
- Upstream neighbour of the surface-read FSM. Collects per-zone distance samples streamed from the ToF sensor interface into a ping-pong (two-bank) frame RAM.
- Asserts drdy once every sensor has delivered a complete frame.
- Serves random reads addressed by {sens, row, col}. The consumer releases its bank with rd_done, so capture of the next frame overlaps with reading of the current one.

Parameters:
- N_SENS, 8, number of sensors; power of two.
- N_ZONES, 64, zones per sensor (8x8); power of two.
- DATA_W, 16, distance sample width in bits.
- Derived: SW = log2(N_SENS) = 3; ZW = log2(N_ZONES) = 6; AW = SW + ZW = 9.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  buffer accepts a sample this cycle.
- s_sens  in  SW  sensor index.
- s_zone  in  ZW  zone index, {row[2:0], col[2:0]}.
- s_dist  in  DATA_W  distance sample.
- s_last  in  1  last sample of this sensor's frame.
- drdy  out  1  one-cycle pulse: a complete frame is available in the read bank.
- rd_addr  in  AW  read address {sens, row, col}.
- rd_data  out  DATA_W  read data, 1-cycle latency.
- rd_done  in  1  one-cycle pulse: consumer has finished with the read bank.
- drop_cnt  out  8  saturating count of dropped samples.

Behaviour:
- Reset values: s_ready=0 in the reset cycle, then 1; drdy=0; rd_data=0; drop_cnt=0; done_mask=0; wr_bank=0; rd_bank_valid=0.
- Handshake:
  - A sample is accepted when s_valid && s_ready.
  - It is written at RAM address {wr_bank, s_sens, s_zone}.
  - The write is visible to reads of that bank from the following cycle.
- done_mask[N_SENS-1:0]: bit s_sens is set on an accepted beat with s_last=1.
- Drops: an accepted beat whose sensor already has its done_mask bit set is not written. drop_cnt increments and saturates at 255. The handshake still completes, so the upstream never hangs.
- Write FSM states: FILL, WAIT_FREE.
  - FILL: s_ready=1. When done_mask becomes all-ones, evaluate in the next cycle:
    - If rd_bank_valid=0, or rd_done is asserted that same cycle: swap. rd_bank <= wr_bank, wr_bank <= ~wr_bank, rd_bank_valid <= 1, done_mask <= 0, drdy pulses for exactly 1 cycle. Stay in FILL.
    - Otherwise go to WAIT_FREE.
  - WAIT_FREE: s_ready=0. On rd_done, perform the swap above, pulse drdy, return to FILL.
- Swap cycle: s_ready=0, so no beat straddles a bank change. Minimum dead time is 1 cycle.
- Read side:
  - rd_data <= RAM[{rd_bank, rd_addr}] every cycle, regardless of rd_bank_valid.
  - rd_done with rd_bank_valid=0 is ignored.
  - rd_done with no pending swap clears rd_bank_valid.
- Simultaneous rd_done and frame completion: the swap takes priority. rd_bank_valid stays 1, pointing at the new bank. No drdy pulse is lost.
- s_last on a beat that completes the mask while a drop also occurs: the drop is counted and the mask is unchanged.
- Zones not delivered before s_last keep stale contents. This is not flagged.
- Reset mid-frame: banks are abandoned, done_mask=0, wr_bank=0, rd_bank_valid=0. RAM contents are not cleared.
- RAM: 2*N_SENS*N_ZONES x DATA_W (1024x16), simple dual-port, one write port and one registered read port. Infers BRAM.

Decomposition:
- Package tof_pkg holds:
  - constants N_SENS, N_ZONES, DATA_W, SW, ZW, AW;
  - typedef tof_addr_t (AW bits) and tof_dist_t (DATA_W bits);
  - write-FSM state enum wr_state_e {FILL, WAIT_FREE}.
- One sub-module, tof_frame_ram: parameterised simple dual-port RAM with synchronous write and registered read. The top level holds the FSM, done_mask, bank pointers and drop counter.

Test Plan:
- Single frame: after reset, stream 512 beats (sens 0..7, zone 0..63, dist = sens*100 + zone, s_last on zone 63) with rd_done never asserted -> exactly one drdy pulse, 1 cycle after the 512th beat. Reading addr 9'h1C5 (sens 7, zone 5) returns 705 one cycle later. drop_cnt=0.
- Backpressure: stream a second full frame without rd_done -> s_ready falls after the 1024th beat. Pulse rd_done 10 cycles later -> drdy fires 1 cycle after rd_done and s_ready returns to 1. Reads now return frame-2 data. Frame-1 data stays readable until the swap.
- Coincident events: time rd_done in the same cycle the mask completes -> a single swap with drdy=1 for 1 cycle, rd_bank_valid=1, no WAIT_FREE entry.
- Duplicate sensor: send sensor 3 frame (s_last set), then 5 more sensor-3 beats with dist=0xFFFF -> drop_cnt=5, stored sensor-3 data unchanged, s_ready stays 1. Also force 300 such beats -> drop_cnt saturates at 255.
- Reset mid-frame: assert rst after 200 beats -> drdy=0, drop_cnt=0, s_ready=0 in the reset cycle then 1. A full fresh frame then produces drdy after exactly 512 beats.
- Interleaved sensors: round-robin beats across sensors with random s_valid gaps -> drdy only after all 8 s_last beats. Readback of all 512 addresses matches the scoreboard.
